// File: rtl/ofs_plat_hssi_xcvr_reset_seq.sv
// Transceiver reset/init sequencer: orders the a2f_* reset controls from f2a_* status and qualifies link_ready.
// Optional relock statistics counter built only when OFS_PLAT_HSSI_RESET_SEQ_STATS_EN is defined.
`timescale 1ns/1ps
module ofs_plat_hssi_xcvr_reset_seq #(
    parameter int NUM_LANES     = 4,
    parameter int T_ANALOG_RST  = 64,
    parameter int T_DIGITAL_RST = 32,
    parameter int LOCK_TIMEOUT  = 65536
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart,
    input  logic                 f2a_init_done,
    input  logic                 f2a_tx_pll_locked,
    input  logic [NUM_LANES-1:0] f2a_tx_cal_busy,
    input  logic [NUM_LANES-1:0] f2a_rx_cal_busy,
    input  logic [NUM_LANES-1:0] f2a_rx_is_lockedtodata,
    output logic                 a2f_init_start,
    output logic [NUM_LANES-1:0] a2f_tx_analogreset,
    output logic [NUM_LANES-1:0] a2f_tx_digitalreset,
    output logic [NUM_LANES-1:0] a2f_rx_analogreset,
    output logic [NUM_LANES-1:0] a2f_rx_digitalreset,
    output logic                 link_ready,
    output logic                 err_timeout,
    output logic [2:0]           seq_state,
    output logic [15:0]          relock_cnt
);

    localparam logic [2:0] S_INIT_REQ  = 3'd0;
    localparam logic [2:0] S_INIT_WAIT = 3'd1;
    localparam logic [2:0] S_TX_ARST   = 3'd2;
    localparam logic [2:0] S_TX_DRST   = 3'd3;
    localparam logic [2:0] S_RX_ARST   = 3'd4;
    localparam logic [2:0] S_RX_DRST   = 3'd5;
    localparam logic [2:0] S_READY     = 3'd6;
    localparam logic [2:0] S_ERROR     = 3'd7;

    localparam int TMR_MAX = (T_ANALOG_RST > T_DIGITAL_RST) ? T_ANALOG_RST : T_DIGITAL_RST;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int TO_W    = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    localparam logic [TMR_W-1:0] TA_LOAD = TMR_W'(T_ANALOG_RST - 1);
    localparam logic [TMR_W-1:0] TD_LOAD = TMR_W'(T_DIGITAL_RST - 1);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);

    logic [2:0]           state_q, state_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [TO_W-1:0]      to_q, to_d;
    logic                 in_wait, timed_out, entry;
    logic                 rx_locked_all, tx_cal_idle, rx_cal_idle;

    logic                 init_start_q, init_start_d;
    logic [NUM_LANES-1:0] tx_arst_q, tx_arst_d;
    logic [NUM_LANES-1:0] tx_drst_q, tx_drst_d;
    logic [NUM_LANES-1:0] rx_arst_q, rx_arst_d;
    logic [NUM_LANES-1:0] rx_drst_q, rx_drst_d;
    logic                 link_q, link_d;
    logic                 err_q, err_d;

    assign rx_locked_all = &f2a_rx_is_lockedtodata;
    assign tx_cal_idle   = ~|f2a_tx_cal_busy;
    assign rx_cal_idle   = ~|f2a_rx_cal_busy;
    assign in_wait       = (state_q >= S_INIT_WAIT) && (state_q <= S_RX_DRST);
    assign timed_out     = in_wait && (to_q == TO_LAST);

    // Priority: restart, then timeout, then the state's own exit condition.
    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = S_INIT_REQ;
        end else if (timed_out) begin
            state_d = S_ERROR;
        end else begin
            case (state_q)
                S_INIT_REQ:  state_d = S_INIT_WAIT;
                S_INIT_WAIT: if (f2a_init_done) state_d = S_TX_ARST;
                S_TX_ARST:   if ((tmr_q == '0) && tx_cal_idle) state_d = S_TX_DRST;
                S_TX_DRST:   if (f2a_tx_pll_locked && (tmr_q == '0)) state_d = S_RX_ARST;
                S_RX_ARST:   if ((tmr_q == '0) && rx_cal_idle) state_d = S_RX_DRST;
                S_RX_DRST:   if (rx_locked_all && (tmr_q == '0)) state_d = S_READY;
                S_READY: begin
                    if (!f2a_tx_pll_locked) state_d = S_TX_ARST;
                    else if (!rx_locked_all) state_d = S_RX_ARST;
                end
                S_ERROR:     state_d = S_ERROR;
                default:     state_d = S_ERROR;
            endcase
        end
    end

    // A restart out of INIT_REQ counts as a fresh entry even though the state code is unchanged.
    assign entry = restart || (state_d != state_q);

    always_comb begin
        tmr_d = tmr_q;
        if (entry) begin
            case (state_d)
                S_TX_ARST, S_RX_ARST: tmr_d = TA_LOAD;
                S_TX_DRST, S_RX_DRST: tmr_d = TD_LOAD;
                default:              tmr_d = '0;
            endcase
        end else begin
            case (state_q)
                S_TX_ARST, S_RX_ARST: begin
                    if (tmr_q != '0) tmr_d = tmr_q - TMR_ONE;
                end
                S_TX_DRST: begin
                    if (!f2a_tx_pll_locked) tmr_d = TD_LOAD;
                    else if (tmr_q != '0) tmr_d = tmr_q - TMR_ONE;
                end
                S_RX_DRST: begin
                    if (!rx_locked_all) tmr_d = TD_LOAD;
                    else if (tmr_q != '0) tmr_d = tmr_q - TMR_ONE;
                end
                default: tmr_d = tmr_q;
            endcase
        end
    end

    assign to_d = (entry || !in_wait) ? '0 : (to_q + TO_ONE);

    // Outputs are decoded from the next state so every control lands on the same edge as the state.
    // init_start is a request pulse; f2a_init_done is its level acknowledge, sampled only in INIT_WAIT.
    always_comb begin
        tx_arst_d    = {NUM_LANES{(state_d inside {S_INIT_REQ, S_INIT_WAIT, S_TX_ARST, S_ERROR})}};
        tx_drst_d    = {NUM_LANES{(state_d inside {S_INIT_REQ, S_INIT_WAIT, S_TX_ARST, S_TX_DRST,
                                                    S_ERROR})}};
        rx_arst_d    = {NUM_LANES{!(state_d inside {S_RX_DRST, S_READY})}};
        rx_drst_d    = {NUM_LANES{(state_d != S_READY)}};
        init_start_d = (state_q == S_INIT_REQ) && (state_d == S_INIT_WAIT);
        link_d       = (state_d == S_READY);
        err_d        = err_q;
        if (restart) err_d = 1'b0;
        else if ((state_d == S_ERROR) && (state_q != S_ERROR)) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_INIT_REQ;
            tmr_q        <= '0;
            to_q         <= '0;
            init_start_q <= 1'b0;
            tx_arst_q    <= '1;
            tx_drst_q    <= '1;
            rx_arst_q    <= '1;
            rx_drst_q    <= '1;
            link_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            to_q         <= to_d;
            init_start_q <= init_start_d;
            tx_arst_q    <= tx_arst_d;
            tx_drst_q    <= tx_drst_d;
            rx_arst_q    <= rx_arst_d;
            rx_drst_q    <= rx_drst_d;
            link_q       <= link_d;
            err_q        <= err_d;
        end
    end

`ifdef OFS_PLAT_HSSI_RESET_SEQ_STATS_EN
    logic [15:0] relock_q, relock_d;

    // Counts READY exits caused by lock loss; restart leaves READY toward INIT_REQ and clears instead.
    always_comb begin
        relock_d = relock_q;
        if (restart) begin
            relock_d = '0;
        end else if ((state_q == S_READY) && (state_d != S_READY) && (relock_q != 16'hFFFF)) begin
            relock_d = relock_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) relock_q <= '0;
        else       relock_q <= relock_d;
    end

    assign relock_cnt = relock_q;
`else
    assign relock_cnt = '0;
`endif

    assign a2f_init_start      = init_start_q;
    assign a2f_tx_analogreset  = tx_arst_q;
    assign a2f_tx_digitalreset = tx_drst_q;
    assign a2f_rx_analogreset  = rx_arst_q;
    assign a2f_rx_digitalreset = rx_drst_q;
    assign link_ready          = link_q;
    assign err_timeout         = err_q;
    assign seq_state           = state_q;

endmodule

// File: tb/tb_ofs_plat_hssi_xcvr_reset_seq.sv
// Bench for the transceiver reset sequencer: phase/age model with per-cycle compare plus directed literal checks.
`timescale 1ns/1ps
module tb_ofs_plat_hssi_xcvr_reset_seq;

    localparam int NL = 4;
    localparam int TA = 8;
    localparam int TD = 4;
    localparam int LT = 100;
    localparam int W  = 38;
`ifdef OFS_PLAT_HSSI_RESET_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          restart = 1'b0;
    logic          init_done = 1'b0;
    logic          pll = 1'b1;
    logic [NL-1:0] tx_cal = '0;
    logic [NL-1:0] rx_cal = '0;
    logic [NL-1:0] lock = '1;

    logic          init_start, link_ready, err_timeout;
    logic [NL-1:0] txa, txd, rxa, rxd;
    logic [2:0]    seq_state;
    logic [15:0]   relock_cnt;

    int tests_run = 0;
    int tests_failed = 0;
    logic [W-1:0] exp_q[$];

    int m_phase = 0, m_age = 0, m_stable = 0, m_relock = 0;
    bit m_err = 1'b0;

    ofs_plat_hssi_xcvr_reset_seq #(
        .NUM_LANES(NL), .T_ANALOG_RST(TA), .T_DIGITAL_RST(TD), .LOCK_TIMEOUT(LT)
    ) dut (
        .clk(clk), .reset(rst), .restart(restart),
        .f2a_init_done(init_done), .f2a_tx_pll_locked(pll),
        .f2a_tx_cal_busy(tx_cal), .f2a_rx_cal_busy(rx_cal),
        .f2a_rx_is_lockedtodata(lock),
        .a2f_init_start(init_start),
        .a2f_tx_analogreset(txa), .a2f_tx_digitalreset(txd),
        .a2f_rx_analogreset(rxa), .a2f_rx_digitalreset(rxd),
        .link_ready(link_ready), .err_timeout(err_timeout),
        .seq_state(seq_state), .relock_cnt(relock_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reset controls follow from how far along the bring-up the link is.
    function automatic logic [W-1:0] pack_exp(input int ph, input bit pulse, input bit err, input int rl);
        logic [3:0]  e_txa, e_txd, e_rxa, e_rxd;
        logic [2:0]  st;
        logic [15:0] r;
        e_txa = (ph >= 3 && ph <= 6) ? 4'h0 : 4'hF;
        e_txd = (ph >= 4 && ph <= 6) ? 4'h0 : 4'hF;
        e_rxa = (ph >= 5 && ph <= 6) ? 4'h0 : 4'hF;
        e_rxd = (ph == 6) ? 4'h0 : 4'hF;
        st = ph[2:0];
        r = STATS ? rl[15:0] : 16'h0;
        return {pulse, e_txa, e_txd, e_rxa, e_rxd, (ph == 6), err, st, r};
    endfunction

    // ---------------- behavioural model ----------------
    task automatic model_step();
        int nxt, s;
        bit pulse;
        nxt = m_phase; s = 0; pulse = 1'b0;
        if (restart) begin
            nxt = 0; m_err = 1'b0; m_relock = 0;
        end else begin
            case (m_phase)
                0: begin nxt = 1; pulse = 1'b1; end
                1, 2, 3, 4, 5: begin
                    if (m_age == LT - 1) begin
                        nxt = 7; m_err = 1'b1;
                    end else begin
                        case (m_phase)
                            1: if (init_done) nxt = 2;
                            2: if (m_age + 1 >= TA && tx_cal == 0) nxt = 3;
                            3: begin s = pll ? m_stable + 1 : 0; if (s >= TD) nxt = 4; end
                            4: if (m_age + 1 >= TA && rx_cal == 0) nxt = 5;
                            5: begin s = (lock == 4'hF) ? m_stable + 1 : 0; if (s >= TD) nxt = 6; end
                            default: ;
                        endcase
                    end
                end
                6: begin
                    if (!pll) nxt = 2;
                    else if (lock != 4'hF) nxt = 4;
                    if (nxt != 6 && m_relock < 65535) m_relock++;
                end
                default: ;
            endcase
        end
        if (restart || nxt != m_phase) begin
            m_age = 0; m_stable = 0;
        end else begin
            m_age++; m_stable = s;
        end
        m_phase = nxt;
        exp_q.push_back(pack_exp(m_phase, pulse, m_err, m_relock));
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase = 0; m_age = 0; m_stable = 0; m_relock = 0; m_err = 1'b0;
                exp_q.delete();
                if (clk) exp_q.push_back(pack_exp(0, 1'b0, 1'b0, 0));
            end else begin
                model_step();
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_init_start", init_start, e[37]);
                check("sb_tx_analogreset", txa, e[36:33]);
                check("sb_tx_digitalreset", txd, e[32:29]);
                check("sb_rx_analogreset", rxa, e[28:25]);
                check("sb_rx_digitalreset", rxd, e[24:21]);
                check("sb_link_ready", link_ready, e[20]);
                check("sb_err_timeout", err_timeout, e[19]);
                check("sb_seq_state", seq_state, e[18:16]);
                check("sb_relock_cnt", relock_cnt, e[15:0]);
            end
        end
    end

    // ---------------- driver tasks (enter and leave on a negedge) ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int max, input string name);
        int cnt;
        cnt = 0;
        while (seq_state !== tgt && cnt < max) begin
            @(negedge clk);
            cnt++;
        end
        check(name, seq_state, tgt);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        tests_failed++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int cnt;
        tick(3);
        check("rst_state", seq_state, 3'd0);
        check("rst_tx_analog", txa, 4'hF);
        check("rst_rx_digital", rxd, 4'hF);
        check("rst_init_start", init_start, 1'b0);
        check("rst_link", link_ready, 1'b0);
        check("rst_err", err_timeout, 1'b0);
        check("rst_relock", relock_cnt, 16'h0);
        rst = 1'b0;

        // nominal bring-up
        @(negedge clk);
        check("t1_init_pulse", init_start, 1'b1);
        check("t1_state_wait", seq_state, 3'd1);
        @(negedge clk);
        check("t1_init_single", init_start, 1'b0);
        tick(3);
        init_done = 1'b1;
        wait_state(3'd2, 20, "t1_reach_tx_arst");
        cnt = 0;
        while (txa !== 4'h0 && cnt < 50) begin @(negedge clk); cnt++; end
        check("t1_tx_arst_len", cnt, 8);
        wait_state(3'd5, 60, "t1_reach_rx_drst");
        cnt = 0;
        while (link_ready !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
        check("t1_rx_drst_len", cnt, 4);
        check("t1_ready_state", seq_state, 3'd6);
        check("t1_ready_resets", {txa, txd, rxa, rxd}, 16'h0);

        // cal busy holds TX analog reset
        tx_cal = 4'b0010;
        pulse_restart();
        wait_state(3'd2, 20, "t2_reach_tx_arst");
        tick(19);
        check("t2_cal_hold", txa, 4'hF);
        tx_cal = 4'h0;
        @(negedge clk);
        check("t2_cal_release", txa, 4'h0);
        wait_state(3'd6, 60, "t2_ready");

        // lock glitch in RX_DRST
        pulse_restart();
        wait_state(3'd5, 80, "t3_reach_rx_drst");
        lock = 4'b1011;
        @(negedge clk);
        lock = 4'hF;
        cnt = 0;
        while (link_ready !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
        check("t3_glitch_delay", cnt, 4);

        // lock loss in READY
        pll = 1'b0;
        @(negedge clk);
        check("t4_link_drop", link_ready, 1'b0);
        check("t4_state", seq_state, 3'd2);
        check("t4_resets", {txa, txd, rxa, rxd}, 16'hFFFF);
        check("t4_relock", relock_cnt, STATS ? 16'd1 : 16'd0);
        pll = 1'b1;
        wait_state(3'd6, 80, "t4_ready_again");
        lock = 4'hE;
        @(negedge clk);
        check("t4_rx_state", seq_state, 3'd4);
        check("t4_rx_resets", {txa, txd, rxa, rxd}, 16'h00FF);
        lock = 4'hF;
        wait_state(3'd6, 60, "t4_ready_rx");
        check("t4_relock2", relock_cnt, STATS ? 16'd2 : 16'd0);

        // timeout in INIT_WAIT
        init_done = 1'b0;
        pulse_restart();
        wait_state(3'd1, 5, "t5_reach_wait");
        cnt = 0;
        while (seq_state !== 3'd7 && cnt < 200) begin @(negedge clk); cnt++; end
        check("t5_timeout_cycles", cnt, 100);
        check("t5_err", err_timeout, 1'b1);
        pulse_restart();
        check("t5_err_clear", err_timeout, 1'b0);
        check("t5_state_req", seq_state, 3'd0);
        @(negedge clk);
        check("t5_init_again", init_start, 1'b1);
        init_done = 1'b1;

        // async reset mid-READY
        wait_state(3'd6, 80, "t6_ready");
        #2 rst = 1'b1;
        #1;
        check("t6_async_state", seq_state, 3'd0);
        check("t6_async_resets", {txa, txd, rxa, rxd}, 16'hFFFF);
        check("t6_async_link", link_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        wait_state(3'd6, 80, "t6_rerun_ready");

        // randomized status traffic
        for (int i = 0; i < 3000; i++) begin
            init_done = ($urandom_range(0, 9) != 0);
            pll       = ($urandom_range(0, 59) != 0);
            tx_cal    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            rx_cal    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            lock      = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            restart   = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        restart = 1'b0; pll = 1'b1; lock = 4'hF; tx_cal = 4'h0; rx_cal = 4'h0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
